// File: rtl/sobel_stream_p.sv
// Streaming 3x3 Sobel edge detector.
// Takes one raster-order pixel per valid/ready transfer, builds the 3x3 window
// from two line buffers plus two column registers, and emits one result per
// interior pixel through a two-stage pipeline (gradients, then abs/mode/saturate).
// The whole pipeline advances only when the output register can move.
module sobel_stream_p #(
  parameter int DW    = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pix,
  input  logic          in_sof,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pix,
  output logic          out_sof,
  output logic          out_eol,
  output logic          frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DW + 3;  // signed gradient width, |g| <= 4*(2^DW-1)

  typedef logic signed [GW-1:0] grad_t;

  // Frame position and frame-stable settings
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_mode;
  logic [DW-1:0] r_thr;

  // Line buffers: r_lb0 holds row r-1, r_lb1 holds row r-2 at the current column
  logic [DW-1:0] r_lb0 [IMG_W];
  logic [DW-1:0] r_lb1 [IMG_W];
  // Window columns c-2 and c-1, index 0 = top row
  logic [DW-1:0] r_cm2 [3];
  logic [DW-1:0] r_cm1 [3];

  // Stage 1
  logic          r_s1_valid, r_s1_sof, r_s1_eol;
  grad_t         r_gx, r_gy;
  logic [1:0]    r_s1_mode;
  logic [DW-1:0] r_s1_thr;

  logic          w_en, w_acc, w_interior;
  logic [CW-1:0] w_col, w_col_nxt;
  logic [RW-1:0] w_row, w_row_nxt;
  logic [1:0]    w_mode;
  logic [DW-1:0] w_thr;
  logic [DW-1:0] w_cur [3];
  grad_t         w_gx, w_gy;
  logic [GW-1:0] w_ax, w_ay, w_sum;
  logic [DW-1:0] w_res;

  function automatic grad_t ext(input logic [DW-1:0] p);
    return grad_t'({3'b000, p});
  endfunction

  function automatic logic [DW-1:0] sat(input logic [GW-1:0] v);
    return (v > GW'({DW{1'b1}})) ? {DW{1'b1}} : v[DW-1:0];
  endfunction

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_acc    = in_valid && w_en;

  // A start-of-frame pixel is always (0,0), whatever the counters say
  assign w_col  = in_sof ? '0 : r_col;
  assign w_row  = in_sof ? '0 : r_row;
  assign w_mode = in_sof ? mode : r_mode;
  assign w_thr  = in_sof ? thr  : r_thr;

  assign w_interior = (w_row >= RW'(2)) && (w_col >= CW'(2));

  assign w_cur[0] = r_lb1[w_col];
  assign w_cur[1] = r_lb0[w_col];
  assign w_cur[2] = in_pix;

  // Window p0..p8: column c-2 = r_cm2, c-1 = r_cm1, c = w_cur
  assign w_gx = (ext(w_cur[0]) + (ext(w_cur[1]) <<< 1) + ext(w_cur[2]))
              - (ext(r_cm2[0]) + (ext(r_cm2[1]) <<< 1) + ext(r_cm2[2]));
  assign w_gy = (ext(r_cm2[0]) + (ext(r_cm1[0]) <<< 1) + ext(w_cur[0]))
              - (ext(r_cm2[2]) + (ext(r_cm1[2]) <<< 1) + ext(w_cur[2]));

  // Next raster position after the accepted pixel
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_col_nxt = w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_col == CW'(IMG_W - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == RW'(IMG_H - 1)) ? '0 : w_row + 1'b1;
    end
  end

  // Position counters, frame settings and sticky framing error
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_mode    <= '0;
      r_thr     <= '0;
      frame_err <= 1'b0;
    end else if (w_acc) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      if (in_sof) begin
        r_mode <= mode;
        r_thr  <= thr;
        if ((r_row != '0) || (r_col != '0)) frame_err <= 1'b1;
      end
    end
  end

  // Line buffer rotation and window shift, one column per accepted pixel
  always_ff @(posedge clk) begin
    // NOTE: buffer storage has no reset; every entry is rewritten before it feeds a valid result.
    if (w_acc) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= in_pix;
      for (int i = 0; i < 3; i++) begin
        r_cm2[i] <= r_cm1[i];
        r_cm1[i] <= w_cur[i];
      end
    end
  end

  // Stage 1: register gradients and per-result control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_acc && w_interior;
      r_s1_sof   <= (w_row == RW'(2)) && (w_col == CW'(2));
      r_s1_eol   <= (w_col == CW'(IMG_W - 1));
      r_gx       <= w_gx;
      r_gy       <= w_gy;
      r_s1_mode  <= w_mode;
      r_s1_thr   <= w_thr;
    end
  end

  assign w_ax  = r_gx[GW-1] ? GW'(-r_gx) : GW'(r_gx);
  assign w_ay  = r_gy[GW-1] ? GW'(-r_gy) : GW'(r_gy);
  assign w_sum = w_ax + w_ay;

  // Output mode selection; the threshold compares the unsaturated sum
  always_comb begin
    w_res = '0;
    case (r_s1_mode)
      2'd0:    w_res = sat(w_sum);
      2'd1:    w_res = sat(w_ax);
      2'd2:    w_res = sat(w_ay);
      default: w_res = (w_sum >= GW'(r_s1_thr)) ? {DW{1'b1}} : '0;
    endcase
  end

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (w_en) begin
      out_valid <= r_s1_valid;
      out_pix   <= w_res;
      out_sof   <= r_s1_valid && r_s1_sof;
      out_eol   <= r_s1_valid && r_s1_eol;
    end
  end

endmodule
